// File: rtl/multi_block_detect.sv
// ---------------------------------------------------------------------------
// multi_block_detect
//
// Watches the hardware CF-Log write stream and detects, on NUM_BLK
// independent channels, when a programmed sequence of (src,dest) entries
// ("block") has been written in order. Each channel tracks its progress
// with a pointer; the block's entry at that pointer is supplied back
// combinationally by the caller. Completed blocks are reported through a
// one-entry valid/ready output register. Lost detections set a sticky flag.
//
// Optional feature: define MULTI_BLOCK_DETECT_STATS_EN to add det_hits,
// per-channel saturating 16-bit completion counters (dropped completions
// are counted too).
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cflow_hw_wen                    CF-Log write strobe, one entry per cycle
//   cflow_log_ptr                   CF-Log address of the current write
//   cflow_src, cflow_dest           current log entry
//   blk_len   [NUM_BLK*LEN_W]       per-channel length, 0 disables
//   blk_id    [NUM_BLK*ID_W]        per-channel block id
//   blk_first_src/dest              per-channel entry 0
//   blk_entry_src/dest              per-channel entry at blk_ptr
//   blk_ptr   [NUM_BLK*LEN_W]       per-channel next expected entry
//   det_valid, det_ready            result handshake
//   det_id, det_addr                id and first-entry address of result
//   det_busy  [NUM_BLK]             channel is mid-block
//   det_overflow, ovf_clr           sticky lost-detection flag and its clear
//   det_hits  [NUM_BLK*16]          (STATS_EN only) completion counters
// ---------------------------------------------------------------------------
module multi_block_detect #(
    parameter int ADDR_W  = 16,
    parameter int NUM_BLK = 4,
    parameter int LEN_W   = 8,
    parameter int ID_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cflow_hw_wen,
    input  logic [ADDR_W-1:0]          cflow_log_ptr,
    input  logic [ADDR_W-1:0]          cflow_src,
    input  logic [ADDR_W-1:0]          cflow_dest,
    input  logic [NUM_BLK*LEN_W-1:0]   blk_len,
    input  logic [NUM_BLK*ID_W-1:0]    blk_id,
    input  logic [NUM_BLK*ADDR_W-1:0]  blk_first_src,
    input  logic [NUM_BLK*ADDR_W-1:0]  blk_first_dest,
    input  logic [NUM_BLK*ADDR_W-1:0]  blk_entry_src,
    input  logic [NUM_BLK*ADDR_W-1:0]  blk_entry_dest,
    output logic [NUM_BLK*LEN_W-1:0]   blk_ptr,
    output logic                       det_valid,
    input  logic                       det_ready,
    output logic [ID_W-1:0]            det_id,
    output logic [ADDR_W-1:0]          det_addr,
    output logic [NUM_BLK-1:0]         det_busy,
    output logic                       det_overflow,
    input  logic                       ovf_clr
`ifdef MULTI_BLOCK_DETECT_STATS_EN
    ,
    output logic [NUM_BLK*16-1:0]      det_hits
`endif
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MONITOR = 1'b1
    } state_t;

    state_t            r_state     [NUM_BLK];
    state_t            w_state_nxt [NUM_BLK];
    logic [LEN_W-1:0]  r_ptr       [NUM_BLK];
    logic [LEN_W-1:0]  w_ptr_nxt   [NUM_BLK];
    logic [ADDR_W-1:0] r_start     [NUM_BLK];
    logic [ADDR_W-1:0] w_start_nxt [NUM_BLK];
    logic [LEN_W-1:0]  w_len       [NUM_BLK];
    logic [ADDR_W-1:0] w_cmp_addr  [NUM_BLK];
    logic [NUM_BLK-1:0] w_first;
    logic [NUM_BLK-1:0] w_match;
    logic [NUM_BLK-1:0] w_cmp;

    logic              r_det_valid;
    logic [ID_W-1:0]   r_det_id;
    logic [ADDR_W-1:0] r_det_addr;
    logic              r_ovf;

    logic              w_any;
    logic              w_multi;
    logic [ID_W-1:0]   w_sel_id;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_load;
    logic              w_ovf_set;

    // Per-channel unpacking of the flat buses and entry comparisons.
    for (genvar g = 0; g < NUM_BLK; g++) begin : g_chan
        assign w_len[g]   = blk_len[g*LEN_W +: LEN_W];
        assign w_first[g] = (cflow_src  == blk_first_src [g*ADDR_W +: ADDR_W]) &&
                            (cflow_dest == blk_first_dest[g*ADDR_W +: ADDR_W]);
        assign w_match[g] = (cflow_src  == blk_entry_src [g*ADDR_W +: ADDR_W]) &&
                            (cflow_dest == blk_entry_dest[g*ADDR_W +: ADDR_W]);
        assign blk_ptr[g*LEN_W +: LEN_W] = r_ptr[g];
        assign det_busy[g] = (r_state[g] == ST_MONITOR);
    end

    // Channel next-state logic. Everything holds unless a write is present.
    always_comb begin
        for (int i = 0; i < NUM_BLK; i++) begin
            // NOTE: every combinationally assigned signal gets a default first
            // so no path leaves it unassigned (which would infer a latch).
            w_state_nxt[i] = r_state[i];
            w_ptr_nxt[i]   = r_ptr[i];
            w_start_nxt[i] = r_start[i];
            w_cmp[i]       = 1'b0;
            w_cmp_addr[i]  = r_start[i];
            if (cflow_hw_wen) begin
                case (r_state[i])
                    ST_IDLE: begin
                        w_ptr_nxt[i] = '0;
                        if (w_first[i] && w_len[i] == LEN_W'(1)) begin
                            // Single-entry block completes on its first write.
                            w_cmp[i]      = 1'b1;
                            w_cmp_addr[i] = cflow_log_ptr;
                        end else if (w_first[i] && w_len[i] > LEN_W'(1)) begin
                            w_state_nxt[i] = ST_MONITOR;
                            w_ptr_nxt[i]   = LEN_W'(1);
                            w_start_nxt[i] = cflow_log_ptr;
                        end
                    end
                    ST_MONITOR: begin
                        if (w_len[i] == '0) begin
                            // Guards len-1 against a disabled channel.
                            w_state_nxt[i] = ST_IDLE;
                            w_ptr_nxt[i]   = '0;
                        end else if (w_match[i]) begin
                            if (r_ptr[i] >= w_len[i] - LEN_W'(1)) begin
                                w_cmp[i]       = 1'b1;
                                w_state_nxt[i] = ST_IDLE;
                                w_ptr_nxt[i]   = '0;
                            end else begin
                                w_ptr_nxt[i] = r_ptr[i] + LEN_W'(1);
                            end
                        end else if (w_first[i]) begin
                            // Broken sequence that is itself a fresh start.
                            w_ptr_nxt[i]   = LEN_W'(1);
                            w_start_nxt[i] = cflow_log_ptr;
                        end else begin
                            w_state_nxt[i] = ST_IDLE;
                            w_ptr_nxt[i]   = '0;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_IDLE;
                        w_ptr_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    // NOTE: the per-channel arrays are small register files, not RAM, so
    // they are reset explicitly; a channel must never resume mid-block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLK; i++) begin
                r_state[i] <= ST_IDLE;
                r_ptr[i]   <= '0;
                r_start[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BLK; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_ptr[i]   <= w_ptr_nxt[i];
                r_start[i] <= w_start_nxt[i];
            end
        end
    end

    // Lowest-index completion wins; any further completion is lost.
    always_comb begin
        w_any      = 1'b0;
        w_multi    = 1'b0;
        w_sel_id   = '0;
        w_sel_addr = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            if (w_cmp[i]) begin
                if (w_any) begin
                    w_multi = 1'b1;
                end else begin
                    w_any      = 1'b1;
                    w_sel_id   = blk_id[i*ID_W +: ID_W];
                    w_sel_addr = w_cmp_addr[i];
                end
            end
        end
    end

    assign w_load    = !r_det_valid || det_ready;
    assign w_ovf_set = w_multi || (w_any && !w_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_det_valid <= 1'b0;
            r_det_id    <= '0;
            r_det_addr  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_load) begin
                r_det_valid <= w_any;
                if (w_any) begin
                    r_det_id   <= w_sel_id;
                    r_det_addr <= w_sel_addr;
                end
            end
            // Setting wins over a simultaneous clear.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign det_valid    = r_det_valid;
    assign det_id       = r_det_id;
    assign det_addr     = r_det_addr;
    assign det_overflow = r_ovf;

`ifdef MULTI_BLOCK_DETECT_STATS_EN
    logic [15:0] r_hits [NUM_BLK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLK; i++) begin
                r_hits[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BLK; i++) begin
                if (w_cmp[i] && r_hits[i] != 16'hFFFF) begin
                    r_hits[i] <= r_hits[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BLK; g++) begin : g_hits
        assign det_hits[g*16 +: 16] = r_hits[g];
    end
`endif

endmodule

// File: tb/tb_multi_block_detect.sv
// ---------------------------------------------------------------------------
// tb_multi_block_detect
//
// Self-checking bench for multi_block_detect. Expected detections are
// pushed to a scoreboard queue as the completing write is driven and are
// popped whenever the DUT hands a result over (det_valid && det_ready).
// Inputs change 1 time unit after the rising edge; the scoreboard samples
// on the falling edge. Define MULTI_BLOCK_DETECT_STATS_EN to also check
// det_hits.
// ---------------------------------------------------------------------------
module tb_multi_block_detect;

    localparam int ADDR_W  = 16;
    localparam int NUM_BLK = 4;
    localparam int LEN_W   = 8;
    localparam int ID_W    = 8;

    logic                      clk;
    logic                      rst_n;
    logic                      cflow_hw_wen;
    logic [ADDR_W-1:0]         cflow_log_ptr;
    logic [ADDR_W-1:0]         cflow_src;
    logic [ADDR_W-1:0]         cflow_dest;
    logic [NUM_BLK*LEN_W-1:0]  blk_len;
    logic [NUM_BLK*ID_W-1:0]   blk_id;
    logic [NUM_BLK*ADDR_W-1:0] blk_first_src;
    logic [NUM_BLK*ADDR_W-1:0] blk_first_dest;
    logic [NUM_BLK*ADDR_W-1:0] blk_entry_src;
    logic [NUM_BLK*ADDR_W-1:0] blk_entry_dest;
    logic [NUM_BLK*LEN_W-1:0]  blk_ptr;
    logic                      det_valid;
    logic                      det_ready;
    logic [ID_W-1:0]           det_id;
    logic [ADDR_W-1:0]         det_addr;
    logic [NUM_BLK-1:0]        det_busy;
    logic                      det_overflow;
    logic                      ovf_clr;
`ifdef MULTI_BLOCK_DETECT_STATS_EN
    logic [NUM_BLK*16-1:0]     det_hits;
`endif

    multi_block_detect #(
        .ADDR_W (ADDR_W),
        .NUM_BLK(NUM_BLK),
        .LEN_W  (LEN_W),
        .ID_W   (ID_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cflow_hw_wen  (cflow_hw_wen),
        .cflow_log_ptr (cflow_log_ptr),
        .cflow_src     (cflow_src),
        .cflow_dest    (cflow_dest),
        .blk_len       (blk_len),
        .blk_id        (blk_id),
        .blk_first_src (blk_first_src),
        .blk_first_dest(blk_first_dest),
        .blk_entry_src (blk_entry_src),
        .blk_entry_dest(blk_entry_dest),
        .blk_ptr       (blk_ptr),
        .det_valid     (det_valid),
        .det_ready     (det_ready),
        .det_id        (det_id),
        .det_addr      (det_addr),
        .det_busy      (det_busy),
        .det_overflow  (det_overflow),
        .ovf_clr       (ovf_clr)
`ifdef MULTI_BLOCK_DETECT_STATS_EN
        ,
        .det_hits      (det_hits)
`endif
    );

    // Block tables: the bench plays the block-definition memory.
    logic [15:0] t_src [NUM_BLK][8];
    logic [15:0] t_dst [NUM_BLK][8];
    logic [7:0]  t_len [NUM_BLK];
    logic [7:0]  t_id  [NUM_BLK];

    always_comb begin
        for (int c = 0; c < NUM_BLK; c++) begin
            blk_len[c*LEN_W +: LEN_W]          = t_len[c];
            blk_id[c*ID_W +: ID_W]             = t_id[c];
            blk_first_src[c*ADDR_W +: ADDR_W]  = t_src[c][0];
            blk_first_dest[c*ADDR_W +: ADDR_W] = t_dst[c][0];
            blk_entry_src[c*ADDR_W +: ADDR_W]  = t_src[c][blk_ptr[c*LEN_W +: 3]];
            blk_entry_dest[c*ADDR_W +: ADDR_W] = t_dst[c][blk_ptr[c*LEN_W +: 3]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ptr_of(input int c);
        return 32'(blk_ptr[c*LEN_W +: LEN_W]);
    endfunction

    // Scoreboard: one result leaves the DUT on every edge where valid&&ready.
    always @(negedge clk) begin
        if (rst_n && det_valid && det_ready) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_det", 32'(exp_q.size()), 32'd1);
            else
                check("sb_det", {8'h00, det_id, det_addr}, exp_q.pop_front());
        end
    end

    task automatic wr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] p);
        cflow_hw_wen  = 1'b1;
        cflow_src     = s;
        cflow_dest    = d;
        cflow_log_ptr = p;
        @(posedge clk);
        #1;
        cflow_hw_wen  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        cflow_hw_wen  = 1'b0;
        cflow_log_ptr = '0;
        cflow_src     = '0;
        cflow_dest    = '0;
        det_ready     = 1'b1;
        ovf_clr       = 1'b0;
        for (int c = 0; c < NUM_BLK; c++) begin
            for (int k = 0; k < 8; k++) begin
                t_src[c][k] = 16'(16'h1000 * (c + 1) + k * 2);
                t_dst[c][k] = 16'(16'h1000 * (c + 1) + k * 2 + 1);
            end
            t_len[c] = 8'd0;
            t_id[c]  = 8'(c);
        end
        // Channel 0: (A,B),(C,D),(E,F)
        t_src[0][0] = 16'h000A; t_dst[0][0] = 16'h000B;
        t_src[0][1] = 16'h000C; t_dst[0][1] = 16'h000D;
        t_src[0][2] = 16'h000E; t_dst[0][2] = 16'h000F;
        t_len[0]    = 8'd3;
        t_id[0]     = 8'hA5;

        #23;
        check("rst_valid", 32'(det_valid), 32'd0);
        check("rst_busy",  32'(det_busy),  32'd0);
        check("rst_ptr",   32'(blk_ptr),   32'd0);
        check("rst_ovf",   32'(det_overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic three-entry block, with write gaps in the middle.
        wr(16'h000A, 16'h000B, 16'h0010);
        check("t1_ptr1",  ptr_of(0), 32'd1);
        check("t1_busy",  32'(det_busy), 32'h1);
        idle(2);
        check("t1_hold",  ptr_of(0), 32'd1);
        wr(16'h000C, 16'h000D, 16'h0011);
        check("t1_ptr2",  ptr_of(0), 32'd2);
        exp_q.push_back({8'h00, 8'hA5, 16'h0010});
        wr(16'h000E, 16'h000F, 16'h0012);
        check("t1_valid", 32'(det_valid), 32'd1);
        check("t1_ptr0",  ptr_of(0), 32'd0);
        check("t1_idle",  32'(det_busy), 32'h0);
        idle(1);
        check("t1_drain", 32'(det_valid), 32'd0);

        // Restart: a repeated first entry re-latches the start address.
        wr(16'h000A, 16'h000B, 16'h0020);
        wr(16'h000A, 16'h000B, 16'h0021);
        check("t2_restart_ptr", ptr_of(0), 32'd1);
        wr(16'h000C, 16'h000D, 16'h0022);
        exp_q.push_back({8'h00, 8'hA5, 16'h0021});
        wr(16'h000E, 16'h000F, 16'h0023);
        check("t2_ovf", 32'(det_overflow), 32'd0);
        idle(1);

        // Disabled channel never leaves IDLE.
        t_len[0] = 8'd0;
        wr(16'h000A, 16'h000B, 16'h0028);
        check("len0_ptr",  ptr_of(0), 32'd0);
        check("len0_busy", 32'(det_busy), 32'h0);

        // Two channels completing together: lowest index wins, overflow set.
        for (int c = 1; c <= 2; c++) begin
            t_src[c][0] = 16'h0100; t_dst[c][0] = 16'h0101;
            t_src[c][1] = 16'h0102; t_dst[c][1] = 16'h0103;
            t_len[c]    = 8'd2;
        end
        t_id[1] = 8'h11;
        t_id[2] = 8'h22;
        wr(16'h0100, 16'h0101, 16'h002F);
        check("t3_busy", 32'(det_busy), 32'h6);
        exp_q.push_back({8'h00, 8'h11, 16'h002F});
        wr(16'h0102, 16'h0103, 16'h0030);
        check("t3_ovf_set", 32'(det_overflow), 32'd1);
        check("t3_id",      32'(det_id), 32'h11);
        idle(1);
        pulse_ovf_clr();
        check("t3_ovf_clr", 32'(det_overflow), 32'd0);
        t_len[1] = 8'd0;
        t_len[2] = 8'd0;

        // Single-entry block completes straight from IDLE.
        t_src[3][0] = 16'h0300; t_dst[3][0] = 16'h0301;
        t_len[3]    = 8'd1;
        t_id[3]     = 8'h33;
        exp_q.push_back({8'h00, 8'h33, 16'h0040});
        wr(16'h0300, 16'h0301, 16'h0040);
        check("len1_valid", 32'(det_valid), 32'd1);
        check("len1_busy",  32'(det_busy), 32'h0);
        idle(1);

        // Backpressure: result held, second completion lost.
        det_ready = 1'b0;
        exp_q.push_back({8'h00, 8'h33, 16'h0050});
        wr(16'h0300, 16'h0301, 16'h0050);
        idle(1);
        check("bp_valid", 32'(det_valid), 32'd1);
        check("bp_addr",  32'(det_addr),  32'h0050);
        check("bp_ovf0",  32'(det_overflow), 32'd0);
        wr(16'h0300, 16'h0301, 16'h0051);
        check("bp_ovf1",  32'(det_overflow), 32'd1);
        check("bp_hold_addr", 32'(det_addr), 32'h0050);
        idle(2);
        check("bp_hold_id",    32'(det_id), 32'h33);
        check("bp_hold_valid", 32'(det_valid), 32'd1);
        det_ready = 1'b1;
        idle(1);
        check("bp_release", 32'(det_valid), 32'd0);
        pulse_ovf_clr();
        t_len[3] = 8'd0;

        // Asynchronous reset in the middle of a block.
        t_len[0] = 8'd3;
        wr(16'h000A, 16'h000B, 16'h0060);
        wr(16'h000C, 16'h000D, 16'h0061);
        check("rst_mid_ptr2", ptr_of(0), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ptr",  ptr_of(0), 32'd0);
        check("rst_mid_busy", 32'(det_busy), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t_len[0] = 8'd1;
        t_id[0]  = 8'h77;
        exp_q.push_back({8'h00, 8'h77, 16'h0070});
        wr(16'h000A, 16'h000B, 16'h0070);
        check("post_rst_valid", 32'(det_valid), 32'd1);

        // Back-to-back completions with ready held high.
        exp_q.push_back({8'h00, 8'h77, 16'h0071});
        wr(16'h000A, 16'h000B, 16'h0071);
        exp_q.push_back({8'h00, 8'h77, 16'h0072});
        wr(16'h000A, 16'h000B, 16'h0072);
        idle(1);
`ifdef MULTI_BLOCK_DETECT_STATS_EN
        check("stats_hits0", 32'(det_hits[15:0]), 32'd3);
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_block_detect.md
MULTI_BLOCK_DETECT -- requirements
Module: multi_block_detect

Interface
REQ-001 Parameters SHALL be: ADDR_W (16, CF-Log address and src/dest width), NUM_BLK (4, parallel block channels), LEN_W (8, block length and pointer width), ID_W (8, block id width).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cflow_hw_wen  in  1  hardware CF-Log write strobe, one transfer per cycle high.
REQ-005 cflow_log_ptr  in  ADDR_W  CF-Log address of the current write.
REQ-006 cflow_src / cflow_dest  in  ADDR_W each  current log entry.
REQ-007 blk_len  in  NUM_BLK*LEN_W  per-channel block length; 0 disables the channel.
REQ-008 blk_id  in  NUM_BLK*ID_W  per-channel block id.
REQ-009 blk_first_src / blk_first_dest  in  NUM_BLK*ADDR_W each  per-channel entry 0.
REQ-010 blk_entry_src / blk_entry_dest  in  NUM_BLK*ADDR_W each  per-channel entry at blk_ptr, combinational lookup.
REQ-011 blk_ptr  out  NUM_BLK*LEN_W  per-channel pointer to the next expected entry.
REQ-012 det_valid / det_ready  out/in  1 each  detection result handshake.
REQ-013 det_id  out  ID_W; det_addr  out  ADDR_W  id of the detected block and CF-Log address of its first entry.
REQ-014 det_busy  out  NUM_BLK  per-channel, high while in MONITOR.
REQ-015 det_overflow  out  1  sticky lost-detection flag; ovf_clr  in  1  clears it.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE and MONITOR, updated only on cycles where cflow_hw_wen=1.
REQ-017 match = (cflow_src,cflow_dest) equals (blk_entry_src,blk_entry_dest) of the channel; first = equals (blk_first_src,blk_first_dest).
REQ-018 IDLE: first and len=1 -> completion, stay IDLE; first and len>1 -> MONITOR, ptr=1, latch cflow_log_ptr as start address; else stay IDLE, ptr=0.
REQ-019 MONITOR: match and ptr<len-1 -> ptr+1; match and ptr=len-1 -> completion, IDLE, ptr=0.
REQ-020 MONITOR mismatch: if first, restart (ptr=1, start address re-latched, stay MONITOR); else IDLE, ptr=0.
REQ-021 Cycles with cflow_hw_wen=0 SHALL hold all channel state, pointers and start addresses.
REQ-022 A channel with len=0 SHALL remain IDLE with ptr=0; a len change mid-MONITOR is not supported.
REQ-023 Completions SHALL load a one-entry output register on the clock edge of the completing write; det_valid is high from the next cycle.
REQ-024 Output register SHALL load when det_valid=0 or det_ready=1 in the same cycle; det_valid, det_id and det_addr are held stable while det_valid=1 and det_ready=0.
REQ-025 Simultaneous completions SHALL select the lowest channel index; each unselected completion, and any completion while the register is full and not draining, sets det_overflow.
REQ-026 ovf_clr SHALL clear det_overflow; a simultaneous set takes priority.
REQ-027 Pointer comparison SHALL use LEN_W-bit unsigned arithmetic; len-1 is never evaluated for len=0.

Reset
REQ-028 rst_n=0 SHALL immediately force all channels to IDLE and clear blk_ptr, start addresses, det_valid, det_id, det_addr, det_busy and det_overflow to 0, including mid-MONITOR.
REQ-029 The first cflow_hw_wen after reset release SHALL be evaluated as IDLE.

Configuration
REQ-030 With MULTI_BLOCK_DETECT_STATS_EN defined: adds output det_hits (NUM_BLK*16), per-channel saturating completion counters including dropped completions, reset to 0, saturating at 16'hFFFF.
REQ-031 Without MULTI_BLOCK_DETECT_STATS_EN: the det_hits port and its counters SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Ch0 len=3 entries (A,B),(C,D),(E,F); writes at log_ptr 0x10,0x11,0x12 -> det_valid next cycle, det_id=blk_id[0], det_addr=0x10.
REQ-033 Ch0 len=3 entries as REQ-032; writes (A,B),(A,B),(C,D),(E,F) at 0x20..0x23 -> restart; det_addr=0x21, no overflow.
REQ-034 Ch1 and ch2 both complete on the same write -> det_id=blk_id[1], det_overflow=1; ovf_clr -> det_overflow=0.
REQ-035 det_ready=0, two separate completions -> first result held stable, det_overflow=1; det_ready=1 -> det_valid falls the next cycle.
REQ-036 rst_n low during MONITOR with ptr=2 -> ptr=0 and det_busy=0 immediately; len=1 single match after release -> detection.
REQ-037 STATS_EN build: 3 completions on ch0 -> det_hits[15:0]=3; non-STATS build compiles without det_hits.
